// File: rtl/pwm_compare_deadtime_pkg.sv
// PKG_pwm: shared types and constants for the PWM carrier/compare path.
//   PWMCOUNT_WIDTH   : MSB index of carrier/compare buses (16-bit carrier).
//   DT_WIDTH_DEFAULT : default width of the dead-time count.
//   _pwm_onoff       : leg enable (PWM_OFF forces the safe state).
//   _dt_state        : dead-time FSM states.
package PKG_pwm;

  localparam int PWMCOUNT_WIDTH   = 15;
  localparam int DT_WIDTH_DEFAULT = 8;

  typedef enum logic {
    PWM_OFF = 1'b0,
    PWM_ON  = 1'b1
  } _pwm_onoff;

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_L_ON  = 3'd1,
    S_DT_LH = 3'd2,
    S_H_ON  = 3'd3,
    S_DT_HL = 3'd4
  } _dt_state;

endpackage

// File: rtl/pwm_compare_deadtime_fsm.sv
// pwm_deadtime_fsm: complementary gate sequencer with dead-time insertion.
// Ports:
//   i_clk, i_rst_n   : clock, async active-low reset
//   i_ref_q          : registered compare result (1 = high side wanted)
//   i_dt             : dead time in cycles (shadowed by the parent)
//   i_enable         : PWM_OFF forces S_OFF and clears the counter
//   o_pwm_h, o_pwm_l : gate commands, decoded from the state register
//   o_dt_active      : high while a dead-time interval runs
//
// state   | meaning
// S_OFF   | leg disabled, both gates low
// S_L_ON  | low side conducting
// S_DT_LH | dead time, heading from low to high side
// S_H_ON  | high side conducting
// S_DT_HL | dead time, heading from high to low side
module pwm_deadtime_fsm
  import PKG_pwm::*;
#(
  parameter int DT_WIDTH = DT_WIDTH_DEFAULT
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_ref_q,
  input  logic [DT_WIDTH-1:0] i_dt,
  input  _pwm_onoff           i_enable,
  output logic                o_pwm_h,
  output logic                o_pwm_l,
  output logic                o_dt_active
);

  _dt_state            r_state;
  logic [DT_WIDTH-1:0] r_cnt;
  logic                w_dt_zero;
  logic                w_cnt_last;

  assign w_dt_zero  = (i_dt == '0);
  // A zero count can only appear in a DT state through corruption; exiting
  // on it as well keeps the FSM from parking with both gates low.
  assign w_cnt_last = (r_cnt <= DT_WIDTH'(1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_OFF;
      r_cnt   <= '0;
    end else if (i_enable != PWM_ON) begin
      r_state <= S_OFF;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_OFF: begin
          // Turn-on always passes through a full dead time.
          if (w_dt_zero) r_state <= i_ref_q ? S_H_ON : S_L_ON;
          else           r_state <= i_ref_q ? S_DT_LH : S_DT_HL;
          r_cnt <= i_dt;
        end
        S_L_ON: begin
          if (i_ref_q) begin
            r_state <= w_dt_zero ? S_H_ON : S_DT_LH;
            r_cnt   <= i_dt;
          end
        end
        S_H_ON: begin
          if (!i_ref_q) begin
            r_state <= w_dt_zero ? S_L_ON : S_DT_HL;
            r_cnt   <= i_dt;
          end
        end
        S_DT_LH: begin
          // A reference pulse shorter than the dead time is swallowed.
          if (!i_ref_q) begin
            r_state <= S_L_ON;
            r_cnt   <= '0;
          end else if (w_cnt_last) begin
            r_state <= S_H_ON;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - DT_WIDTH'(1);
          end
        end
        S_DT_HL: begin
          if (i_ref_q) begin
            r_state <= S_H_ON;
            r_cnt   <= '0;
          end else if (w_cnt_last) begin
            r_state <= S_L_ON;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - DT_WIDTH'(1);
          end
        end
        default: begin
          r_state <= S_OFF;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_pwm_h     = (r_state == S_H_ON);
  assign o_pwm_l     = (r_state == S_L_ON);
  assign o_dt_active = (r_state == S_DT_LH) || (r_state == S_DT_HL);

endmodule

// File: rtl/pwm_compare_deadtime.sv
// pwm_compare_deadtime: carrier/compare modulator driving one half-bridge leg.
// Compare and dead time are shadowed and only change on mask_event (or
// continuously while off), so a duty change never splits a carrier period.
// Ports:
//   clk, reset      : clock, async active-low reset
//   carrier         : carrier value from the carrier generator
//   mask_event      : one-cycle shadow-load strobe
//   compare         : requested duty threshold
//   deadtime        : requested dead time in cycles
//   pwm_onoff       : leg enable
//   pwm_h, pwm_l    : high/low-side gate commands
//   dt_active       : dead-time interval running
//   compare_active  : compare value currently in effect
module pwm_compare_deadtime
  import PKG_pwm::*;
#(
  parameter int DT_WIDTH = DT_WIDTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [PWMCOUNT_WIDTH:0]   carrier,
  input  logic                      mask_event,
  input  logic [PWMCOUNT_WIDTH:0]   compare,
  input  logic [DT_WIDTH-1:0]       deadtime,
  input  _pwm_onoff                 pwm_onoff,
  output logic                      pwm_h,
  output logic                      pwm_l,
  output logic                      dt_active,
  output logic [PWMCOUNT_WIDTH:0]   compare_active
);

  logic [PWMCOUNT_WIDTH:0] r_compare;
  logic [DT_WIDTH-1:0]     r_dt_active_val;
  logic                    r_ref_q;
  logic                    w_load;

  // Shadows are transparent while off so the first period after turn-on
  // already uses the requested values.
  assign w_load = (pwm_onoff == PWM_OFF) || mask_event;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_compare       <= '0;
      r_dt_active_val <= '0;
      r_ref_q         <= 1'b0;
    end else begin
      if (w_load) begin
        r_compare       <= compare;
        r_dt_active_val <= deadtime;
      end
      // Comparison uses the value in effect before this edge's shadow load.
      r_ref_q <= (carrier < r_compare);
    end
  end

  assign compare_active = r_compare;

  pwm_deadtime_fsm #(
    .DT_WIDTH (DT_WIDTH)
  ) u_fsm (
    .i_clk       (clk),
    .i_rst_n     (reset),
    .i_ref_q     (r_ref_q),
    .i_dt        (r_dt_active_val),
    .i_enable    (pwm_onoff),
    .o_pwm_h     (pwm_h),
    .o_pwm_l     (pwm_l),
    .o_dt_active (dt_active)
  );

endmodule

// File: tb/tb_pwm_compare_deadtime.sv
// Self-checking bench for pwm_compare_deadtime. The reference model tracks
// the intended gate side, how long that intent has persisted and which side
// was last driven; a side turns on once its intent has lasted dead time + 1
// edges, or at once if it is the side that was driven before the interval.
module tb_pwm_compare_deadtime;
  import PKG_pwm::*;

  localparam int DTW = DT_WIDTH_DEFAULT;
  localparam int CW  = PWMCOUNT_WIDTH + 1;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [PWMCOUNT_WIDTH:0] carrier;
  logic                    mask_event;
  logic [PWMCOUNT_WIDTH:0] compare;
  logic [DTW-1:0]          deadtime;
  _pwm_onoff               pwm_onoff;
  logic                    pwm_h;
  logic                    pwm_l;
  logic                    dt_active;
  logic [PWMCOUNT_WIDTH:0] compare_active;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pwm_compare_deadtime #(.DT_WIDTH(DTW)) dut (
    .clk            (clk),
    .reset          (reset),
    .carrier        (carrier),
    .mask_event     (mask_event),
    .compare        (compare),
    .deadtime       (deadtime),
    .pwm_onoff      (pwm_onoff),
    .pwm_h          (pwm_h),
    .pwm_l          (pwm_l),
    .dt_active      (dt_active),
    .compare_active (compare_active)
  );

  // reference model state
  int m_cmp, m_dt, m_ref, m_run, m_prev, m_last;
  int m_h, m_l, m_dta;

  // carrier generator (sawtooth 0..per-1, mask at minimum)
  int per  = 200;
  int cval = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset;
    m_cmp = 0; m_dt = 0; m_ref = 0; m_run = 0; m_prev = 0; m_last = 0;
    m_h = 0; m_l = 0; m_dta = 0;
  endtask

  task automatic model_edge;
    int intent;
    bit on;
    intent = m_ref;
    on     = (pwm_onoff == PWM_ON);
    m_ref  = (int'(carrier) < m_cmp) ? 1 : 0;
    if (!on) begin
      m_h = 0; m_l = 0; m_dta = 0; m_run = 0;
    end else begin
      if (m_run == 0) begin
        m_last = 1 - intent;
        m_run  = 1;
      end else if (intent == m_prev) begin
        if (m_run < 100000) m_run++;
      end else begin
        m_run = 1;
      end
      m_prev = intent;
      if (intent == m_last || m_run >= m_dt + 1) begin
        m_last = intent;
        m_h = (intent == 1) ? 1 : 0;
        m_l = (intent == 0) ? 1 : 0;
        m_dta = 0;
      end else begin
        m_h = 0; m_l = 0; m_dta = 1;
      end
    end
    if (!on || mask_event) begin
      m_cmp = int'(compare);
      m_dt  = int'(deadtime);
    end
  endtask

  task automatic check_outputs;
    check_eq("pwm_h", 32'(pwm_h), 32'(m_h));
    check_eq("pwm_l", 32'(pwm_l), 32'(m_l));
    check_eq("dt_active", 32'(dt_active), 32'(m_dta));
    check_eq("compare_active", 32'(compare_active), 32'(m_cmp));
    check_eq("overlap", 32'(pwm_h & pwm_l), 32'd0);
  endtask

  task automatic step;
    @(posedge clk);
    if (!reset) model_reset();
    else        model_edge();
    #1;
    check_outputs();
  endtask

  task automatic apply_carrier;
    carrier    = CW'(cval);
    mask_event = (cval == 0);
    cval       = (cval + 1) % per;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      apply_carrier();
      step();
    end
  endtask

  task automatic restart(input int cmp, input int dt);
    pwm_onoff = PWM_OFF;
    compare   = CW'(cmp);
    deadtime  = DTW'(dt);
    cval      = 0;
    run(3);
    cval      = 0;
    pwm_onoff = PWM_ON;
  endtask

  task automatic measure(input string tag, input int eh, input int el, input int ed, input int edt);
    int nh = 0;
    int nl = 0;
    int nd = 0;
    int ndt = 0;
    repeat (per) begin
      apply_carrier();
      step();
      nh  += int'(pwm_h);
      nl  += int'(pwm_l);
      nd  += int'(!pwm_h && !pwm_l);
      ndt += int'(dt_active);
    end
    check_eq({tag, "_h_cycles"}, 32'(nh), 32'(eh));
    check_eq({tag, "_l_cycles"}, 32'(nl), 32'(el));
    check_eq({tag, "_dead_cycles"}, 32'(nd), 32'(ed));
    check_eq({tag, "_dt_cycles"}, 32'(ndt), 32'(edt));
  endtask

  initial begin
    int nd;
    int found;
    int len;

    reset      = 1'b1;
    carrier    = '0;
    mask_event = 1'b0;
    compare    = '0;
    deadtime   = '0;
    pwm_onoff  = PWM_OFF;
    #2 reset = 1'b0;
    model_reset();
    #1 check_outputs();

    // inputs toggle while reset is held
    for (int i = 0; i < 10; i++) begin
      carrier    = CW'($urandom_range(0, 300));
      compare    = CW'($urandom_range(0, 300));
      deadtime   = DTW'($urandom_range(0, 20));
      mask_event = 1'($urandom_range(0, 1));
      pwm_onoff  = ($urandom_range(0, 1) == 1) ? PWM_ON : PWM_OFF;
      step();
    end
    reset = 1'b1;

    // steady PWM
    per = 200;
    restart(100, 5);
    run(400);
    measure("steady", 95, 95, 10, 10);

    // shadow update mid-period
    run(120);
    compare = CW'(50);
    run(80);
    run(200);
    measure("shadow", 45, 145, 10, 10);

    // dt = 0
    restart(100, 0);
    run(400);
    measure("dt0", 100, 100, 0, 0);

    // 4-cycle ref pulse swallowed by dt = 10
    restart(4, 10);
    run(400);
    measure("pulse", 0, 196, 4, 4);

    // saturation
    restart(0, 5);
    run(400);
    measure("sat_lo", 0, 200, 0, 0);
    restart(201, 5);
    run(400);
    measure("sat_hi", 200, 0, 0, 0);

    // off in the middle of S_DT_LH, then back on
    restart(100, 5);
    run(400);
    run(2);
    check_eq("dt_lh_entered", 32'(dt_active), 32'd1);
    pwm_onoff = PWM_OFF;
    run(1);
    check_eq("off_clears_dt", 32'(dt_active), 32'd0);
    run(2);
    pwm_onoff = PWM_ON;
    nd = 0;
    found = 0;
    for (int i = 0; i < 50; i++) begin
      apply_carrier();
      step();
      if (pwm_h || pwm_l) begin
        found = 1;
        break;
      end
      nd++;
    end
    check_eq("reon_gate_seen", 32'(found), 32'd1);
    check_eq("reon_dead_cycles", 32'(nd), 32'd5);

    // async reset while the high side is on
    found = 0;
    for (int i = 0; i < 400; i++) begin
      apply_carrier();
      step();
      if (pwm_h) begin
        found = 1;
        break;
      end
    end
    check_eq("h_on_reached", 32'(found), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_eq("async_rst_h", 32'(pwm_h), 32'd0);
    check_eq("async_rst_l", 32'(pwm_l), 32'd0);
    check_eq("async_rst_cmp", 32'(compare_active), 32'd0);
    model_reset();
    run(2);
    reset = 1'b1;

    // randomized segments
    for (int s = 0; s < 40; s++) begin
      per       = int'($urandom_range(20, 250));
      cval      = int'($urandom_range(0, per - 1));
      pwm_onoff = PWM_OFF;
      deadtime  = DTW'($urandom_range(0, 12));
      compare   = CW'($urandom_range(0, per + 1));
      run(2);
      pwm_onoff = PWM_ON;
      len = int'($urandom_range(100, 600));
      for (int c = 0; c < len; c++) begin
        apply_carrier();
        if ($urandom_range(0, 49) == 0) mask_event = 1'b1;
        if ($urandom_range(0, 29) == 0) compare = CW'($urandom_range(0, per + 1));
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
